// File: rtl/adder_tree_pkg.sv
// Shared helpers for the pipelined adder tree: tree depth, per-level element
// counts and the saturating clamp used on the narrow output.
package adder_tree_pkg;

  localparam int MAXW = 64;

  typedef struct packed {
    logic            flag;
    logic [MAXW-1:0] value;
  } sat_t;

  // ceil(log2(n)), never below 1 so a two-channel tree still has one level.
  function automatic int tree_depth(input int n);
    int d;
    d = 1;
    for (int i = 1; i < 31; i++) begin
      if ((1 << i) < n) d = i + 1;
    end
    return d;
  endfunction

  // Number of live elements after l pairwise reductions of n channels.
  function automatic int level_count(input int n, input int l);
    return (n + (1 << l) - 1) >> l;
  endfunction

  function automatic logic signed [MAXW-1:0] max_val(input int width);
    logic signed [MAXW-1:0] one;
    one = 1;
    return (one <<< (width - 1)) - 1;
  endfunction

  function automatic logic signed [MAXW-1:0] min_val(input int width);
    logic signed [MAXW-1:0] one;
    one = 1;
    return -(one <<< (width - 1));
  endfunction

  function automatic sat_t sat_clamp(input logic signed [MAXW-1:0] value, input int width);
    sat_t r;
    r.flag  = 1'b0;
    r.value = value;
    if (value > max_val(width)) begin
      r.flag  = 1'b1;
      r.value = max_val(width);
    end else if (value < min_val(width)) begin
      r.flag  = 1'b1;
      r.value = min_val(width);
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// One registered reduction level: sums adjacent pairs, widening by one bit.
// An odd trailing element is registered unchanged (added to zero).
module adder_tree_level #(
  parameter int N_IN = 8,
  parameter int IW   = 16
) (
  input  logic                                  clk,
  input  logic                                  rst,
  input  logic                                  ce,
  input  logic [N_IN*IW-1:0]                    din,
  output logic [((N_IN + 1) / 2)*(IW + 1)-1:0]  dout
);

  localparam int N_OUT = (N_IN + 1) / 2;
  localparam int OW    = IW + 1;

  logic [N_OUT*OW-1:0] sum_d;

  for (genvar k = 0; k < N_OUT; k++) begin : g_node
    logic signed [OW-1:0] a;
    logic signed [OW-1:0] b;

    assign a = {din[2*k*IW + IW - 1], din[2*k*IW +: IW]};
    if (2*k + 1 < N_IN) begin : g_pair
      assign b = {din[(2*k+1)*IW + IW - 1], din[(2*k+1)*IW +: IW]};
    end else begin : g_odd
      assign b = '0;
    end
    assign sum_d[k*OW +: OW] = a + b;
  end

  // NOTE: clocked state uses non-blocking assignments so every stage samples
  // the previous stage's pre-edge value, independent of process order.
  always_ff @(posedge clk) begin
    if (rst) begin
      dout <= '0;
    end else if (ce) begin
      dout <= sum_d;
    end
  end

endmodule

// File: rtl/adder_tree_pipe.sv
// Fully pipelined signed adder tree with valid tracking, clock-enable stall
// and an optional saturated narrow output that follows each sample.
module adder_tree_pipe
  import adder_tree_pkg::*;
#(
  parameter int DIW    = 16,
  parameter int NUM_IN = 8,
  parameter int LVL    = tree_depth(NUM_IN),
  parameter int DOW    = DIW + LVL,
  parameter int SOW    = DIW
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ce,
  input  logic                  in_valid,
  input  logic [NUM_IN*DIW-1:0] din,
  input  logic                  sat_en,
  output logic                  out_valid,
  output logic signed [DOW-1:0] sum,
  output logic signed [SOW-1:0] sat_sum,
  output logic                  sat_flag
);

  // Every level fits in this width; unused upper bits are zero-padded.
  localparam int BUSW = NUM_IN * DOW;

  logic [NUM_IN*DIW-1:0] din_q;
  logic [LVL:0]          valid_pipe;
  logic [LVL:0]          sat_pipe;
  logic [BUSW-1:0]       lvl_bus [LVL+1];

  // NOTE: pipeline data registers are reset too, so a flushed pipe presents
  // zeros rather than stale data after rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      din_q      <= '0;
      valid_pipe <= '0;
      sat_pipe   <= '0;
    end else if (ce) begin
      din_q      <= din;
      valid_pipe <= {valid_pipe[LVL-1:0], in_valid};
      sat_pipe   <= {sat_pipe[LVL-1:0], sat_en};
    end
  end

  assign lvl_bus[0] = BUSW'(din_q);

  for (genvar n = 1; n <= LVL; n++) begin : g_lvl
    localparam int NI = level_count(NUM_IN, n - 1);
    localparam int IW = DIW + n - 1;
    localparam int NO = level_count(NUM_IN, n);

    logic [NO*(IW+1)-1:0] q;

    adder_tree_level #(
      .N_IN (NI),
      .IW   (IW)
    ) u_level (
      .clk  (clk),
      .rst  (rst),
      .ce   (ce),
      .din  (lvl_bus[n-1][NI*IW-1:0]),
      .dout (q)
    );

    assign lvl_bus[n] = BUSW'(q);
  end

  logic signed [DOW-1:0] tree_out;
  sat_t                  clamp;

  assign tree_out = lvl_bus[LVL][DOW-1:0];
  assign clamp    = sat_clamp(MAXW'(tree_out), SOW);

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      sum       <= '0;
      sat_sum   <= '0;
      sat_flag  <= 1'b0;
    end else if (ce) begin
      out_valid <= valid_pipe[LVL];
      sum       <= tree_out;
      if (sat_pipe[LVL]) begin
        sat_sum  <= clamp.value[SOW-1:0];
        sat_flag <= clamp.flag;
      end else begin
        sat_sum  <= tree_out[SOW-1:0];
        sat_flag <= 1'b0;
      end
    end
  end

endmodule
